pid_controller: RTL and testbench
=================================

Name: pid_controller

Overview:
Closed-loop speed controller that consumes the gains produced by the PID tuner (Kp, Ki, Kd, tuning_done). It turns the measured commutation period and a target period into a PWM duty command for the commutation/PWM stage. Each sample_tick starts one PID evaluation. A single shared multiplier evaluates the three terms over a fixed multi-cycle sequence, then the result is saturated and registered as the duty output.

Parameters:
DATA_WIDTH, 16, width of period inputs; gains are DATA_WIDTH/2 bits
FRAC_BITS, 4, fractional bits of the unsigned gains (Q4.4 at default; 16 = 1.0)
INT_WIDTH, 24, signed integral accumulator width
INT_LIMIT, 1048575, symmetric integral clamp magnitude (must be < 2^(INT_WIDTH-1))
DUTY_WIDTH, 10, duty output width; DUTY_MAX = 2^DUTY_WIDTH-1

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
enable  in  1  controller run enable
sample_tick  in  1  single-cycle pulse that starts one evaluation
gains_valid  in  1  tuner tuning_done
Kp  in  DATA_WIDTH/2  proportional gain, unsigned, FRAC_BITS fraction
Ki  in  DATA_WIDTH/2  integral gain, unsigned
Kd  in  DATA_WIDTH/2  derivative gain, unsigned
setpoint_period  in  DATA_WIDTH  target period in clock cycles
period_speed  in  DATA_WIDTH  measured period in clock cycles
duty  out  DUTY_WIDTH  registered duty command
duty_valid  out  1  one-cycle pulse when duty updates
busy  out  1  high while an evaluation is in progress
overrun  out  1  sticky; set when sample_tick arrives while busy

Behaviour:
- Reset: all outputs 0, state IDLE, integral=0, prev_error=0, latched gains=0. Reset applies in any state, including mid-evaluation; next cycle is IDLE with duty=0.
- Only reset clears overrun.
- enable=0 or gains_valid=0 in IDLE: sample_tick ignored, duty forced to 0, integral and prev_error cleared, no duty_valid pulse.
- FSM: IDLE -> CAPTURE -> MUL_P -> MUL_I -> MUL_D -> SUM -> SAT -> IDLE.
- Leaving IDLE requires sample_tick && enable && gains_valid.
- busy=1 in every state except IDLE.
- CAPTURE:
  - latch Kp/Ki/Kd and both periods
  - e = period_speed - setpoint_period, 17-bit signed; positive means motor too slow
  - integral = clamp(integral + e, -INT_LIMIT, +INT_LIMIT)
  - d = e - prev_error, 18-bit signed
  - prev_error <= e
- MUL_P, MUL_I, MUL_D: one shared signed multiply per state (Kp*e, Ki*integral, Kd*d). Gains are zero-extended to signed; each product is sign-extended into a 36-bit signed accumulator.
- SUM: acc_shifted = acc >>> FRAC_BITS (arithmetic shift; truncation toward -inf).
- SAT:
  - duty <= 0 if acc_shifted < 0
  - duty <= DUTY_MAX if acc_shifted > DUTY_MAX
  - otherwise duty <= acc_shifted[DUTY_WIDTH-1:0]
  - duty_valid=1 for this cycle only
- Latency: sample_tick seen at cycle T; duty and duty_valid update at the edge ending cycle T+6. busy deasserts at T+7, and a new tick is accepted from T+7.
- sample_tick while busy: ignored and overrun<=1; the evaluation in progress is unaffected.
- Gains are sampled only in CAPTURE. Changes to Kp/Ki/Kd mid-evaluation have no effect until the next tick.
- enable or gains_valid falling mid-evaluation: the current evaluation completes. The controller then behaves as disabled in IDLE (duty returns to 0 the following cycle).
- No overflow is possible: the 36-bit accumulator exceeds the worst-case sum of the three products.

Test Plan:
1. P only: Kp=16, Ki=Kd=0, setpoint=1000, period=1100, one tick -> duty=100, duty_valid pulses exactly 6 cycles after the tick; then period=900 -> duty=0 (clamped low).
2. I only with clamp: INT_LIMIT=1000, Ki=16, e=+10 on three ticks -> duty 10, 20, 30. Then e=+600 twice -> integral sticks at 1000, duty=1000; e=+5000 -> duty stays at 1000 (DUTY_MAX=1023 not reached).
3. D only: Kd=16, setpoint=1000, periods 1000 then 1050 then 1050 -> duty 0, 50, 0.
4. Saturation high: Kp=255, e=+10000 -> duty=1023.
5. Overrun and gating: second tick 3 cycles after the first -> ignored, overrun=1 and stays 1. Tick with gains_valid=0 -> no duty_valid, duty=0, integral cleared (next enabled I-only tick gives duty = Ki*e>>4 from zero).
6. Reset mid-evaluation: assert reset during MUL_I -> next cycle busy=0, duty=0, overrun=0, no duty_valid; a subsequent tick gives a fresh result (prev_error=0).

Source files
------------

// File: rtl/pid_controller.sv
// ============================================================================
// Module   : pid_controller
// Purpose  : Sampled PID speed loop; one shared multiplier, saturated duty out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pid_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 4,
  parameter int INT_WIDTH  = 24,
  parameter int INT_LIMIT  = 1048575,
  parameter int DUTY_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sample_tick,
  input  logic                      gains_valid,
  input  logic [DATA_WIDTH/2-1:0]   Kp,
  input  logic [DATA_WIDTH/2-1:0]   Ki,
  input  logic [DATA_WIDTH/2-1:0]   Kd,
  input  logic [DATA_WIDTH-1:0]     setpoint_period,
  input  logic [DATA_WIDTH-1:0]     period_speed,
  output logic [DUTY_WIDTH-1:0]     duty,
  output logic                      duty_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int c_gain_w  = DATA_WIDTH / 2;
  localparam int c_err_w   = DATA_WIDTH + 1;
  localparam int c_der_w   = DATA_WIDTH + 2;
  localparam int c_opx_w   = (INT_WIDTH > c_der_w) ? INT_WIDTH : c_der_w;
  localparam int c_prod_w  = c_gain_w + 1 + c_opx_w;
  localparam int c_acc_w   = 36;

  localparam logic signed [INT_WIDTH:0]   c_lim_pos  = INT_LIMIT;
  localparam logic signed [INT_WIDTH:0]   c_lim_neg  = -INT_LIMIT;
  localparam logic signed [c_acc_w-1:0]   c_duty_max = (1 << DUTY_WIDTH) - 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    MUL_P   = 3'd2,
    MUL_I   = 3'd3,
    MUL_D   = 3'd4,
    SUM     = 3'd5,
    SAT     = 3'd6
  } state_t;

  state_t                        r_state;
  logic [c_gain_w-1:0]           r_kp;
  logic [c_gain_w-1:0]           r_ki;
  logic [c_gain_w-1:0]           r_kd;
  logic signed [c_err_w-1:0]     r_err;
  logic signed [c_err_w-1:0]     r_prev_err;
  logic signed [c_der_w-1:0]     r_deriv;
  logic signed [INT_WIDTH-1:0]   r_integral;
  logic signed [c_acc_w-1:0]     r_acc;
  logic signed [c_acc_w-1:0]     r_acc_sh;

  logic signed [c_err_w-1:0]     w_err;
  logic signed [INT_WIDTH:0]     w_int_sum;
  logic signed [INT_WIDTH-1:0]   w_int_next;
  logic signed [c_der_w-1:0]     w_deriv;
  logic signed [c_gain_w:0]      w_op_g;
  logic signed [c_opx_w-1:0]     w_op_x;
  logic signed [c_prod_w-1:0]    w_prod;
  logic signed [c_acc_w-1:0]     w_prod_ext;

  // Positive error means the measured period is longer than target (too slow).
  assign w_err     = $signed({1'b0, period_speed}) - $signed({1'b0, setpoint_period});
  assign w_int_sum = (INT_WIDTH+1)'(r_integral) + (INT_WIDTH+1)'(w_err);
  assign w_deriv   = c_der_w'(w_err) - c_der_w'(r_prev_err);

  always_comb begin
    w_int_next = w_int_sum[INT_WIDTH-1:0];
    if (w_int_sum > c_lim_pos) begin
      w_int_next = c_lim_pos[INT_WIDTH-1:0];
    end else if (w_int_sum < c_lim_neg) begin
      w_int_next = c_lim_neg[INT_WIDTH-1:0];
    end
  end

  // Operand select for the single shared multiplier.
  always_comb begin
    w_op_g = '0;
    w_op_x = '0;
    case (r_state)
      MUL_P: begin
        w_op_g = $signed({1'b0, r_kp});
        w_op_x = c_opx_w'(r_err);
      end
      MUL_I: begin
        w_op_g = $signed({1'b0, r_ki});
        w_op_x = c_opx_w'(r_integral);
      end
      MUL_D: begin
        w_op_g = $signed({1'b0, r_kd});
        w_op_x = c_opx_w'(r_deriv);
      end
      default: begin
        w_op_g = '0;
        w_op_x = '0;
      end
    endcase
  end

  assign w_prod     = c_prod_w'(w_op_g) * c_prod_w'(w_op_x);
  assign w_prod_ext = c_acc_w'(w_prod);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_kp       <= '0;
      r_ki       <= '0;
      r_kd       <= '0;
      r_err      <= '0;
      r_prev_err <= '0;
      r_deriv    <= '0;
      r_integral <= '0;
      r_acc      <= '0;
      r_acc_sh   <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (sample_tick && (r_state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (!enable || !gains_valid) begin
            duty       <= '0;
            r_integral <= '0;
            r_prev_err <= '0;
          end else if (sample_tick) begin
            r_state <= CAPTURE;
            busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          r_kp       <= Kp;
          r_ki       <= Ki;
          r_kd       <= Kd;
          r_err      <= w_err;
          r_integral <= w_int_next;
          r_deriv    <= w_deriv;
          r_prev_err <= w_err;
          r_state    <= MUL_P;
        end
        MUL_P: begin
          r_acc   <= w_prod_ext;
          r_state <= MUL_I;
        end
        MUL_I: begin
          r_acc   <= r_acc + w_prod_ext;
          r_state <= MUL_D;
        end
        MUL_D: begin
          r_acc   <= r_acc + w_prod_ext;
          r_state <= SUM;
        end
        SUM: begin
          r_acc_sh <= r_acc >>> FRAC_BITS;
          r_state  <= SAT;
        end
        SAT: begin
          if (r_acc_sh[c_acc_w-1]) begin
            duty <= '0;
          end else if (r_acc_sh > c_duty_max) begin
            duty <= '1;
          end else begin
            duty <= r_acc_sh[DUTY_WIDTH-1:0];
          end
          duty_valid <= 1'b1;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pid_controller.sv
// ============================================================================
// Module   : tb_pid_controller
// Purpose  : Directed vectors with hand-computed duty results for pid_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pid_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_tick;
  logic        gains_valid;
  logic [7:0]  kp;
  logic [7:0]  ki;
  logic [7:0]  kd;
  logic [15:0] sp;
  logic [15:0] per;
  logic [9:0]  duty;
  logic        duty_valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  pid_controller #(
    .DATA_WIDTH(16),
    .FRAC_BITS (4),
    .INT_WIDTH (24),
    .INT_LIMIT (1000),
    .DUTY_WIDTH(10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sample_tick    (sample_tick),
    .gains_valid    (gains_valid),
    .Kp             (kp),
    .Ki             (ki),
    .Kd             (kd),
    .setpoint_period(sp),
    .period_speed   (per),
    .duty           (duty),
    .duty_valid     (duty_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  task automatic check_val(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
  endtask

  // Latency counts negedges after the edge that sampled the tick.
  task automatic wait_result(input string tag, input int start, input int exp_duty);
    int lat;
    bit seen;
    lat  = start;
    seen = 1'b0;
    while (!seen && lat < 14) begin
      @(negedge clk);
      lat++;
      if (duty_valid) seen = 1'b1;
    end
    check_val({tag, "_lat"}, seen ? lat : -1, 6);
    check_val(tag, int'(duty), exp_duty);
    @(negedge clk);
    check_val({tag, "_pulse"}, int'(duty_valid), 0);
  endtask

  task automatic run_eval(input string tag, input int s, input int p, input int exp_duty);
    sp  = 16'(s);
    per = 16'(p);
    pulse_tick();
    wait_result(tag, 0, exp_duty);
  endtask

  task automatic clear_state();
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    @(negedge clk) enable = 1'b1;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (duty_valid) seen = 1'b1;
    end
    check_val(tag, int'(seen), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; sample_tick = 1'b0; gains_valid = 1'b0;
    kp = '0; ki = '0; kd = '0; sp = '0; per = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_duty", int'(duty), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_ovr", int'(overrun), 0);
    check_val("rst_valid", int'(duty_valid), 0);
    enable = 1'b1;
    gains_valid = 1'b1;

    // Proportional only
    kp = 8'd16;
    run_eval("p_pos", 1000, 1100, 100);
    run_eval("p_neg", 1000, 900, 0);
    clear_state();
    kp = 8'd24;
    run_eval("p_frac", 1000, 1101, 151);

    // Integral only, clamp at 1000
    clear_state();
    kp = 8'd0; ki = 8'd16;
    run_eval("i_1", 1000, 1010, 10);
    run_eval("i_2", 1000, 1010, 20);
    run_eval("i_3", 1000, 1010, 30);
    run_eval("i_600a", 1000, 1600, 630);
    run_eval("i_600b", 1000, 1600, 1000);
    run_eval("i_5000", 1000, 6000, 1000);

    // Derivative only
    clear_state();
    ki = 8'd0; kd = 8'd16;
    run_eval("d_1", 1000, 1000, 0);
    run_eval("d_2", 1000, 1050, 50);
    run_eval("d_3", 1000, 1050, 0);

    // Saturation high; Kp change and enable drop mid-evaluation have no effect
    clear_state();
    kd = 8'd0; kp = 8'd255;
    sp = 16'd1000; per = 16'd11000;
    pulse_tick();
    @(negedge clk) kp = 8'd0;
    @(negedge clk) enable = 1'b0;
    wait_result("sat_hi", 2, 1023);
    check_val("dis_duty", int'(duty), 0);
    check_val("dis_busy", int'(busy), 0);
    enable = 1'b1;

    // Overrun: second tick during MUL_I
    clear_state();
    ki = 8'd16;
    sp = 16'd1000; per = 16'd1020;
    pulse_tick();
    @(negedge clk);
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    wait_result("ovr_eval", 3, 20);
    check_val("ovr_set", int'(overrun), 1);
    check_val("ovr_idle", int'(busy), 0);
    expect_quiet("ovr_no_extra", 8);
    check_val("ovr_sticky", int'(overrun), 1);

    // Gated tick clears integral
    gains_valid = 1'b0;
    per = 16'd1010;
    pulse_tick();
    expect_quiet("gate_no_valid", 10);
    check_val("gate_duty", int'(duty), 0);
    gains_valid = 1'b1;
    run_eval("gate_fresh", 1000, 1010, 10);
    check_val("gate_ovr", int'(overrun), 1);

    // Reset during MUL_I aborts and clears prev_error
    ki = 8'd0; kd = 8'd16;
    sp = 16'd1000; per = 16'd1040;
    pulse_tick();
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_val("mrst_busy", int'(busy), 0);
    check_val("mrst_duty", int'(duty), 0);
    check_val("mrst_ovr", int'(overrun), 0);
    check_val("mrst_valid", int'(duty_valid), 0);
    expect_quiet("mrst_quiet", 10);
    run_eval("mrst_fresh", 1000, 1040, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
